// File: rtl/serial_paralelo_align_pkg.sv
// Shared definitions for the serial link lane: comma symbol, lock depth and RX FSM encoding.
// Also imported by the TX parallel-to-serial stage so both ends agree on the idle symbol.
package serial_paralelo_align_pkg;

  localparam logic [7:0] COMMA_BC       = 8'hBC;
  localparam int         LOCK_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sp_state_t;

  // Increment that sticks at the limit so the comma counter never wraps.
  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/serial_paralelo_align_shift8.sv
// Bit-level front end: serial shift register plus byte-phase counter.
// Exposes the candidate byte (history + current bit) and the byte-boundary flag.
module sp_shift8 (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       hunt,
  output logic [7:0] nxt,
  output logic       boundary
);

  // Only the seven most recent bits are needed to form the candidate byte.
  logic [6:0] sr;
  logic [2:0] bit_cnt;

  assign nxt      = {sr, data_in};
  assign boundary = !hunt && (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr <= nxt[6:0];
      // Held at zero while hunting so the phase restarts right after a comma match.
      if (hunt)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/serial_paralelo_align.sv
// Per-lane RX aligner: hunts for the idle comma, locks byte phase, strips commas from the byte stream.
// Optional build macro SP_REALIGN_EN: drop lock and re-hunt after two misaligned commas while LOCKED.
module serial_paralelo_align
  import serial_paralelo_align_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_BC,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       byte_strobe,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  sp_state_t  state;
  logic [3:0] comma_cnt;
  logic [7:0] nxt;
  logic       boundary;
  logic       is_comma;

  assign is_comma = (nxt == COMMA);

  sp_shift8 u_shift8 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .hunt     (state == HUNT),
    .nxt      (nxt),
    .boundary (boundary)
  );

`ifdef SP_REALIGN_EN
  logic [1:0] misalign_cnt;
`endif

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      comma_cnt   <= '0;
      data_out    <= 8'h00;
      byte_strobe <= 1'b0;
      valid_out   <= 1'b0;
      active      <= 1'b0;
`ifdef SP_REALIGN_EN
      misalign_cnt <= '0;
`endif
    end else begin
      byte_strobe <= 1'b0;
      valid_out   <= 1'b0;
      case (state)
        HUNT: begin
          if (is_comma) begin
            comma_cnt <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state  <= LOCKED;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (boundary) begin
            data_out    <= nxt;
            byte_strobe <= 1'b1;
            if (is_comma) begin
              comma_cnt <= sat_inc(comma_cnt, LOCK_N);
              if (comma_cnt + 4'd1 >= LOCK_N) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              comma_cnt <= '0;
              state     <= HUNT;
            end
          end
        end
        LOCKED: begin
`ifdef SP_REALIGN_EN
          if (misalign_cnt == 2'd2) begin
            // Phase has slipped: abandon the partial byte and search again.
            state        <= HUNT;
            active       <= 1'b0;
            comma_cnt    <= '0;
            misalign_cnt <= '0;
          end else if (boundary) begin
            data_out    <= nxt;
            byte_strobe <= 1'b1;
            valid_out   <= !is_comma;
            if (is_comma)
              misalign_cnt <= '0;
          end else if (is_comma) begin
            misalign_cnt <= misalign_cnt + 2'd1;
          end
`else
          if (boundary) begin
            data_out    <= nxt;
            byte_strobe <= 1'b1;
            valid_out   <= !is_comma;
          end
`endif
        end
        default: begin
          state     <= HUNT;
          comma_cnt <= '0;
          active    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Directed bench for serial_paralelo_align: lock, comma stripping, failed alignment, resets, realign.
// Expectations adapt to the SP_REALIGN_EN build macro.
module tb_serial_paralelo_align;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       byte_strobe;
  logic       valid_out;
  logic       active;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SP_REALIGN_EN
  localparam bit REALIGN = 1'b1;
`else
  localparam bit REALIGN = 1'b0;
`endif

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_align dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .byte_strobe (byte_strobe),
    .valid_out   (valid_out),
    .active      (active)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Sends one byte MSB first; after its LSB edge checks strobe/valid/active (and data_out when strobed).
  task automatic send_byte(input string tag, input logic [7:0] b, input bit do_chk,
                           input logic es, input logic ev, input logic ea);
    int mid;
    mid = 0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      mid += int'(byte_strobe);
    end
    send_bit(b[0]);
    $display("%0t %s byte=%02h strobe=%0b valid=%0b data_out=%02h active=%0b",
             $time, tag, b, byte_strobe, valid_out, data_out, active);
    if (do_chk) begin
      chk({tag, ".mid_strobe"}, 8'(mid), 8'd0);
      chk({tag, ".strobe"}, {7'd0, byte_strobe}, {7'd0, es});
      chk({tag, ".valid"}, {7'd0, valid_out}, {7'd0, ev});
      chk({tag, ".active"}, {7'd0, active}, {7'd0, ea});
      if (es) chk({tag, ".data"}, data_out, b);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b0;
    #12;
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  initial begin
    int sv;
    reset   = 1'b1;
    data_in = 1'b0;
    #3;
    chk("rst.data", data_out, 8'h00);
    chk("rst.strobe", {7'd0, byte_strobe}, 8'd0);
    chk("rst.valid", {7'd0, valid_out}, 8'd0);
    chk("rst.active", {7'd0, active}, 8'd0);
    @(negedge clk_32f);
    reset = 1'b0;

    // Lock after junk bits, then first data byte
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte("lock.bc1", 8'hBC, 1, 0, 0, 0);
    send_byte("lock.bc2", 8'hBC, 1, 1, 0, 0);
    send_byte("lock.bc3", 8'hBC, 1, 1, 0, 0);
    send_byte("lock.bc4", 8'hBC, 1, 1, 0, 1);
    send_byte("lock.a5",  8'hA5, 1, 1, 1, 1);

    // Comma stripping
    send_byte("strip.bc", 8'hBC, 1, 1, 0, 1);
    send_byte("strip.12", 8'h12, 1, 1, 1, 1);
    send_byte("strip.bc", 8'hBC, 1, 1, 0, 1);
    send_byte("strip.34", 8'h34, 1, 1, 1, 1);
    send_byte("strip.56", 8'h56, 1, 1, 1, 1);

    // Failed alignment: a data byte during ALIGN sends the block back to HUNT
    do_reset();
    send_byte("fail.bc1", 8'hBC, 1, 0, 0, 0);
    send_byte("fail.bc2", 8'hBC, 1, 1, 0, 0);
    send_byte("fail.7e",  8'h7E, 1, 1, 0, 0);
    send_byte("fail.bc3", 8'hBC, 1, 0, 0, 0);
    send_byte("fail.bc4", 8'hBC, 1, 1, 0, 0);
    send_byte("fail.bc5", 8'hBC, 1, 1, 0, 0);
    send_byte("fail.bc6", 8'hBC, 1, 1, 0, 1);
    send_byte("fail.a5",  8'hA5, 1, 1, 1, 1);

    // Asynchronous reset in the middle of data byte C3
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    #2 reset = 1'b1;
    #1;
    $display("%0t async reset mid C3: data_out=%02h strobe=%0b valid=%0b active=%0b",
             $time, data_out, byte_strobe, valid_out, active);
    chk("arst.data", data_out, 8'h00);
    chk("arst.strobe", {7'd0, byte_strobe}, 8'd0);
    chk("arst.valid", {7'd0, valid_out}, 8'd0);
    chk("arst.active", {7'd0, active}, 8'd0);
    #2 reset = 1'b0;
    sv = 0;
    send_bit(1'b0); sv += int'(byte_strobe) + int'(valid_out);
    send_bit(1'b0); sv += int'(byte_strobe) + int'(valid_out);
    send_bit(1'b1); sv += int'(byte_strobe) + int'(valid_out);
    send_bit(1'b1); sv += int'(byte_strobe) + int'(valid_out);
    chk("arst.c3_tail", 8'(sv), 8'd0);
    send_byte("relock.bc1", 8'hBC, 1, 0, 0, 0);
    send_byte("relock.bc2", 8'hBC, 1, 1, 0, 0);
    send_byte("relock.bc3", 8'hBC, 1, 1, 0, 0);
    send_byte("relock.bc4", 8'hBC, 1, 1, 0, 1);
    send_byte("relock.a5",  8'hA5, 1, 1, 1, 1);

    // Phase slip by 3 bits followed by a run of commas
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_byte("slip.bc1", 8'hBC, 0, 0, 0, 0);
    send_byte("slip.bc2", 8'hBC, 0, 0, 0, 0);
    chk("slip.bc2.active", {7'd0, active}, 8'd1);
    send_byte("slip.bc3", 8'hBC, 0, 0, 0, 0);
    chk("slip.bc3.active", {7'd0, active}, REALIGN ? 8'd0 : 8'd1);
    send_byte("slip.bc4", 8'hBC, 0, 0, 0, 0);
    send_byte("slip.bc5", 8'hBC, 0, 0, 0, 0);
    chk("slip.bc5.active", {7'd0, active}, REALIGN ? 8'd0 : 8'd1);
    send_byte("slip.bc6", 8'hBC, 0, 0, 0, 0);
    chk("slip.bc6.active", {7'd0, active}, 8'd1);
    if (REALIGN)
      send_byte("slip.a5", 8'hA5, 1, 1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
